// File: rtl/mux4_scan_ctrl.sv
// mux4_scan_ctrl: walks the select of a downstream combinational 4:1 one-bit mux across
// the enabled channels and registers each channel's value into a 4-bit snapshot.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset (highest priority)
//   start    - scan request, honoured only while idle
//   mask     - channel enables, latched when start is accepted
//   mux_out  - output of the downstream 4:1 mux
//   sel      - select driven to the mux
//   sample   - captured snapshot, bit i = channel i
//   busy     - high while scanning
//   done     - one-cycle pulse at the end of a scan
module mux4_scan_ctrl #(
    parameter int unsigned DWELL = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] mask,
    input  logic       mux_out,
    output logic [1:0] sel,
    output logic [3:0] sample,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [3:0]         sample_q, sample_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         mask_q, mask_d;

    logic [1:0]         first_chan;
    logic [2:0]         next_info;   // {found, channel}

    // Lowest enabled channel of the requested mask.
    function automatic logic [1:0] lowest_chan(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Next enabled channel strictly above cur; no wrap-around.
    function automatic logic [2:0] next_chan(input logic [3:0] m, input logic [1:0] cur);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    assign first_chan = lowest_chan(mask);
    assign next_info  = next_chan(mask_q, sel_q);

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        sample_d = sample_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        mask_d   = mask_q;

        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (start) begin
                    mask_d = mask;
                    if (mask != 4'b0000) begin
                        sample_d = sample_q & mask;  // disabled channels read as 0
                        sel_d    = first_chan;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = StScan;
                    end else begin
                        sample_d = 4'b0000;
                        done_d   = 1'b1;
                        state_d  = StDone;
                    end
                end
            end
            StScan: begin
                cnt_d = cnt_q + 1'b1;
                // Capture on the last dwell cycle so sel has been stable for DWELL cycles.
                if (cnt_q == CNT_W'(DWELL - 1)) begin
                    sample_d[sel_q] = mux_out;
                    cnt_d           = '0;
                    if (next_info[2]) begin
                        sel_d = next_info[1:0];
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            sel_q    <= 2'b00;
            sample_q <= 4'b0000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            mask_q   <= 4'b0000;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            sample_q <= sample_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
        end
    end

    assign sel    = sel_q;
    assign sample = sample_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
module tb_mux4_scan_ctrl;

    logic       clk;
    logic       rst;

    // DWELL=2 instance
    logic       start2;
    logic [3:0] mask2;
    logic [3:0] in2;
    logic       mux_out2;
    logic [1:0] sel2;
    logic [3:0] sample2;
    logic       busy2;
    logic       done2;

    // DWELL=1 instance
    logic       start1;
    logic [3:0] mask1;
    logic [3:0] in1;
    logic       mux_out1;
    logic [1:0] sel1;
    logic [3:0] sample1;
    logic       busy1;
    logic       done1;

    int errors;
    int checks;

    // Behavioural 4:1 muxes in front of each controller.
    assign mux_out2 = in2[sel2];
    assign mux_out1 = in1[sel1];

    mux4_scan_ctrl #(.DWELL(2), .CNT_W(8)) u_dut2 (
        .clk     (clk),
        .rst     (rst),
        .start   (start2),
        .mask    (mask2),
        .mux_out (mux_out2),
        .sel     (sel2),
        .sample  (sample2),
        .busy    (busy2),
        .done    (done2)
    );

    mux4_scan_ctrl #(.DWELL(1), .CNT_W(8)) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .start   (start1),
        .mask    (mask1),
        .mux_out (mux_out1),
        .sel     (sel1),
        .sample  (sample1),
        .busy    (busy1),
        .done    (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Full DWELL=2 scan, in=1010 mask=1111. disturb: re-pulse start at cycle 3 and change
    // mask at cycle 4. rst_at>=0: reset during that cycle and abort.
    task automatic scan_1111(input string tag, input bit disturb, input int rst_at);
        in2    = 4'b1010;
        mask2  = 4'b1111;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check({tag, "_sel"}, {2'b00, sel2}, 4'(i / 2));
            check({tag, "_busy"}, {3'b000, busy2}, 4'd1);
            check({tag, "_done_low"}, {3'b000, done2}, 4'd0);
            if (disturb && i == 3) start2 = 1'b1;
            if (disturb && i == 4) begin
                start2 = 1'b0;
                mask2  = 4'b0001;
            end
            if (i == rst_at) rst = 1'b1;
            step();
            if (i == rst_at) begin
                rst = 1'b0;
                check({tag, "_rst_sel"}, {2'b00, sel2}, 4'd0);
                check({tag, "_rst_sample"}, sample2, 4'b0000);
                check({tag, "_rst_busy"}, {3'b000, busy2}, 4'd0);
                check({tag, "_rst_done"}, {3'b000, done2}, 4'd0);
                step();
                check({tag, "_rst_nodone"}, {3'b000, done2}, 4'd0);
                check({tag, "_rst_idle"}, {3'b000, busy2}, 4'd0);
                return;
            end
        end
        check({tag, "_done"}, {3'b000, done2}, 4'd1);
        check({tag, "_busy_end"}, {3'b000, busy2}, 4'd0);
        check({tag, "_sample"}, sample2, 4'b1010);
        step();
        check({tag, "_done_pulse"}, {3'b000, done2}, 4'd0);
        mask2 = 4'b1111;
    endtask

    logic [3:0] exp6;

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        start2 = 1'b0;
        mask2  = 4'b0000;
        in2    = 4'b0000;
        start1 = 1'b0;
        mask1  = 4'b0000;
        in1    = 4'b0000;
        exp6   = 4'b0000;
        step();
        step();
        rst = 1'b0;
        check("rst_sel", {2'b00, sel2}, 4'd0);
        check("rst_sample", sample2, 4'b0000);
        check("rst_busy", {3'b000, busy2}, 4'd0);
        check("rst_done", {3'b000, done2}, 4'd0);
        check("rst_sample1", sample1, 4'b0000);
        step();

        // 1: full scan
        scan_1111("s1", 1'b0, -1);
        step();

        // 2: sparse mask, previously-set bits 1 and 3 must clear
        in2    = 4'b0111;
        mask2  = 4'b0101;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        check("s2_clear", sample2, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            check("s2_sel", {2'b00, sel2}, (i < 2) ? 4'd0 : 4'd2);
            check("s2_busy", {3'b000, busy2}, 4'd1);
            step();
        end
        check("s2_done", {3'b000, done2}, 4'd1);
        check("s2_sample", sample2, 4'b0101);
        step();
        check("s2_done_pulse", {3'b000, done2}, 4'd0);
        step();

        // 3: empty mask
        mask2  = 4'b0000;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        check("s3_busy", {3'b000, busy2}, 4'd0);
        check("s3_done", {3'b000, done2}, 4'd1);
        check("s3_sample", sample2, 4'b0000);
        step();
        check("s3_done_pulse", {3'b000, done2}, 4'd0);
        check("s3_busy_after", {3'b000, busy2}, 4'd0);
        step();

        // 4: start re-pulse and mask change mid-scan are ignored
        scan_1111("s4", 1'b1, -1);
        step();

        // 5: reset mid-scan, then a clean scan
        scan_1111("s5a", 1'b0, 5);
        scan_1111("s5b", 1'b0, -1);
        step();

        // 6: DWELL=1 with toggling inputs
        in1    = 4'b0110;
        mask1  = 4'b1111;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("s6_sel", {2'b00, sel1}, 4'(i));
            check("s6_busy", {3'b000, busy1}, 4'd1);
            exp6[i] = in1[i];
            step();
            in1 = ~in1;
        end
        check("s6_done", {3'b000, done1}, 4'd1);
        check("s6_sample", sample1, exp6);
        step();
        check("s6_done_pulse", {3'b000, done1}, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux4_scan_ctrl.md
Name: mux4_scan_ctrl

Overview:
- Sequencer that sits directly upstream of the 4:1 one-bit mux.
- Drives the mux select `sel[1:0]` and walks it across the enabled input channels.
- Registers the mux output for each channel into a 4-bit snapshot, so four single-bit sources can be sampled through one mux with a start/done handshake.
- The mux is purely combinational; this block is the only sequential element on the path.

Parameters:
- DWELL, default 2: clock cycles `sel` is held on each channel before its value is captured. Legal range is 1..255.
- CNT_W, default 8: width of the internal dwell counter. Must satisfy 2^CNT_W > DWELL.

Ports:
- clk  input  1  system clock; all logic updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  scan request; acted on only in IDLE.
- mask  input  4  channel enable; bit i enables mux input i. Latched when start is accepted.
- mux_out  input  1  output of the downstream 4:1 mux.
- sel  output  2  select driven to the 4:1 mux.
- sample  output  4  captured snapshot; bit i holds the value of channel i.
- busy  output  1  high while a scan is in progress (SCAN state).
- done  output  1  one-cycle pulse when a scan completes.

Behaviour:
- Reset (rst high at a rising edge):
  - state=IDLE, sel=2'b00, sample=4'b0000, busy=0, done=0, dwell counter=0, latched mask=0.
  - rst has priority over every other input.
  - Reset mid-scan aborts the scan immediately, with no done pulse.
- States: IDLE, SCAN, DONE. The state is fully registered; all outputs are registers.
- IDLE:
  - busy=0, done=0; sel holds its last value.
  - start=1 and mask!=0:
    - latch mask;
    - clear the sample bits whose mask bit is 0;
    - sel <= lowest enabled channel;
    - counter <= 0; busy <= 1; go to SCAN.
  - start=1 and mask==0: sample <= 0; go to DONE (busy stays 0).
- SCAN:
  - Each cycle: counter increments.
  - When counter==DWELL-1 at a rising edge:
    - sample[sel] <= mux_out;
    - counter <= 0;
    - if a higher-numbered enabled channel exists, sel <= next enabled channel (ascending, no wrap);
    - otherwise busy <= 0, done <= 1, go to DONE.
  - start is ignored while in SCAN.
  - External mask changes during SCAN have no effect; only the latched copy is used.
- DONE:
  - done=1 for exactly this one cycle; unconditional return to IDLE.
  - start asserted during DONE is ignored. It must be held, or re-asserted, in IDLE.
- Timing:
  - With start accepted at edge E, the first channel is presented from E.
  - Channel k (0-based among the enabled set) is captured at edge E+(k+1)*DWELL.
  - With n enabled channels, done is high during the cycle after edge E+n*DWELL.
- Mux settling: the capture happens on the last cycle of the dwell, so sel has been stable for DWELL cycles. DWELL=1 is legal because the mux is combinational.
- Sample bits update only at capture edges or at scan start (masked clear); otherwise they hold.

Test Plan:
1. DWELL=2; real 4:1 mux with in3..in0=1010; mask=1111; one start pulse -> sel runs 0,0,1,1,2,2,3,3 over the 8 cycles after the start edge; busy high for those 8 cycles; done pulses on the 9th cycle; sample=4'b1010.
2. DWELL=2; in3..in0=0111; mask=0101 -> sel runs 0,0,2,2 while busy; done on the 5th cycle; sample=4'b0101; bits 1 and 3 are 0 even if previously 1.
3. mask=0000 with start -> busy never asserts; done is high in the cycle after the start edge; sample=4'b0000.
4. During scenario 1, pulse start again at cycle 3 and change mask to 0001 at cycle 4 -> sequence, sample and done timing identical to scenario 1.
5. During scenario 1, assert rst for one edge at cycle 5 -> next cycle state=IDLE, sel=0, sample=0, busy=0; no done pulse. A following start produces a clean full scan.
6. DWELL=1, mask=1111, inputs toggled each cycle -> sel changes every cycle (0,1,2,3); sample[i] equals the input value during the cycle sel==i; done on the 5th cycle.
